// File: rtl/iot_byte_packer.sv
// Packs a byte stream into wide words, first byte MSB. A word is presented on the edge that takes its last byte.
// Backpressure: one word in out, one more held in asm. busy stays high while asm holds a word.
module iot_byte_packer #(
  parameter int DATA_W      = 128,
  parameter int BYTE_W      = 8,
  parameter int ROUND_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_en,
  input  logic [BYTE_W-1:0]              iot_in,
  input  logic                           flush,
  output logic                           busy,
  output logic                           word_valid,
  input  logic                           word_ready,
  output logic [DATA_W-1:0]              word_data,
  output logic [$clog2(ROUND_WORDS)-1:0] word_idx,
  output logic                           round_last,
  output logic                           overrun
);

  localparam int IDX_W   = $clog2(ROUND_WORDS);
  localparam int BYTES   = DATA_W / BYTE_W;
  localparam int CNT_W   = $clog2(BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROUND_WORDS - 1);

  logic [DATA_W-1:0] asm_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              asm_full_q;
  logic [IDX_W-1:0]  load_cnt_q;

  logic [DATA_W-1:0] asm_word;
  logic              accept;
  logic              complete;
  logic              hs;
  logic              load_from_asm;
  logic              load_new;
  logic              load;

  assign asm_word      = {asm_q[DATA_W-BYTE_W-1:0], iot_in};
  assign accept        = in_en & ~asm_full_q;
  assign complete      = accept & (cnt_q == CNT_LAST);
  assign hs            = word_valid & word_ready;
  // asm_full and complete are mutually exclusive, so at most one load source fires.
  assign load_from_asm = hs & asm_full_q;
  assign load_new      = complete & (~word_valid | hs);
  assign load          = load_from_asm | load_new;

  assign busy       = asm_full_q;
  assign round_last = word_valid & (word_idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q      <= '0;
      cnt_q      <= '0;
      asm_full_q <= 1'b0;
      load_cnt_q <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_idx   <= '0;
      overrun    <= 1'b0;
    end else begin
      // A byte offered while asm is full is lost, even on a flush edge.
      if (in_en && asm_full_q) begin
        overrun <= 1'b1;
      end
      if (flush) begin
        cnt_q      <= '0;
        asm_full_q <= 1'b0;
        load_cnt_q <= '0;
        word_valid <= 1'b0;
        word_idx   <= '0;
      end else begin
        if (accept) begin
          asm_q <= asm_word;
          cnt_q <= cnt_q + 1'b1;
        end
        if (load_from_asm) begin
          word_data  <= asm_q;
          asm_full_q <= 1'b0;
        end else if (load_new) begin
          word_data <= asm_word;
        end else if (hs) begin
          word_valid <= 1'b0;
        end
        if (complete && !load_new) begin
          asm_full_q <= 1'b1;
        end
        if (load) begin
          word_valid <= 1'b1;
          word_idx   <= load_cnt_q;
          load_cnt_q <= (load_cnt_q == IDX_LAST) ? '0 : load_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_iot_byte_packer.sv
// Scoreboard bench: a byte-queue model predicts words, indices, busy and overrun; a monitor checks the DUT.
module tb_iot_byte_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_en = 1'b0;
  logic [7:0]   iot_in = 8'h00;
  logic         flush = 1'b0;
  logic         busy;
  logic         word_valid;
  logic         word_ready = 1'b0;
  logic [127:0] word_data;
  logic [2:0]   word_idx;
  logic         round_last;
  logic         overrun;

  int tests = 0;
  int fails = 0;

  iot_byte_packer dut (
    .clk        (clk),
    .rst        (rst),
    .in_en      (in_en),
    .iot_in     (iot_in),
    .flush      (flush),
    .busy       (busy),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_idx   (word_idx),
    .round_last (round_last),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words awaiting consumption, partial bytes, next index.
  typedef struct packed {
    logic [127:0] d;
    logic [2:0]   i;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] part_q[$];
  int         pending = 0;
  int         nidx = 0;
  bit         ovr_m = 0;
  bit         m_hs;
  exp_t       m_e;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      part_q.delete();
      pending = 0;
      nidx    = 0;
      ovr_m   = 0;
    end else begin
      if (in_en && pending == 2) ovr_m = 1;
      if (flush) begin
        exp_q.delete();
        part_q.delete();
        pending = 0;
        nidx    = 0;
      end else begin
        m_hs = (pending > 0) && word_ready;
        if (in_en && pending < 2) begin
          part_q.push_back(iot_in);
          if (part_q.size() == 16) begin
            m_e.d = '0;
            for (int k = 0; k < 16; k++) m_e.d[127-8*k -: 8] = part_q[k];
            m_e.i = 3'(nidx);
            exp_q.push_back(m_e);
            nidx = (nidx + 1) % 8;
            pending++;
            part_q.delete();
          end
        end
        if (m_hs) pending--;
      end
    end
  end

  // Monitor: inputs settle 2ns after posedge, so negedge sees what the next edge will use.
  always @(negedge clk) begin
    if (rst) begin
      chk("busy", 128'(busy), 128'(pending == 2));
      chk("word_valid", 128'(word_valid), 128'(pending > 0));
      chk("overrun", 128'(overrun), 128'(ovr_m));
      if (word_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 128'(word_valid), 128'(0));
        end else begin
          chk("word_data", word_data, exp_q[0].d);
          chk("word_idx", 128'(word_idx), 128'(exp_q[0].i));
          chk("round_last", 128'(round_last), 128'(exp_q[0].i == 3'd7));
          if (word_ready && !flush) void'(exp_q.pop_front());
        end
      end else begin
        chk("round_last_idle", 128'(round_last), 128'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_en  = 1'b1;
    iot_in = b;
    tick();
    in_en  = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(word_valid), 128'(0));
    chk("rst_data", word_data, 128'(0));
    chk("rst_idx", 128'(word_idx), 128'(0));
    chk("rst_last", 128'(round_last), 128'(0));
    chk("rst_overrun", 128'(overrun), 128'(0));
    #19 rst = 1'b1;
    tick();

    // Single word with consumer ready.
    word_ready = 1'b1;
    for (int b = 0; b < 16; b++) send_byte(8'(b));
    idle(3);

    // Nine back-to-back words: full round then wrap to idx 0.
    for (int b = 0; b < 144; b++) send_byte(8'($urandom));
    idle(3);

    // Backpressure: two words stacked, overrun while busy, then drain.
    pulse_flush();
    word_ready = 1'b0;
    for (int b = 0; b < 32; b++) send_byte(8'($urandom));
    send_byte(8'hAA);
    send_byte(8'hAA);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    idle(3);
    word_ready = 1'b1;
    idle(2);
    for (int b = 0; b < 16; b++) send_byte(8'(b + 8'h40));
    idle(3);

    // Flush mid-word.
    for (int b = 0; b < 7; b++) send_byte(8'(b + 8'h60));
    pulse_flush();
    for (int b = 0; b < 16; b++) send_byte(8'(b + 8'h10));
    idle(3);

    // Async reset between edges while a partial word and sticky overrun exist.
    word_ready = 1'b0;
    for (int b = 0; b < 16; b++) send_byte(8'(b + 8'h80));
    for (int b = 0; b < 5; b++) send_byte(8'(b + 8'hC0));
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_valid", 128'(word_valid), 128'(0));
    chk("arst_data", word_data, 128'(0));
    chk("arst_idx", 128'(word_idx), 128'(0));
    chk("arst_last", 128'(round_last), 128'(0));
    chk("arst_overrun", 128'(overrun), 128'(0));
    tick();
    rst = 1'b1;
    tick();
    word_ready = 1'b1;
    for (int b = 0; b < 16; b++) send_byte(8'(b + 8'hE0));
    idle(3);

    // Randomized traffic with occasional protocol violations and flushes.
    for (int c = 0; c < 3000; c++) begin
      in_en      = ($urandom_range(0, 3) != 0) && (!busy || $urandom_range(0, 49) == 0);
      iot_in     = 8'($urandom);
      word_ready = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 399) == 0);
      tick();
    end
    in_en      = 1'b0;
    flush      = 1'b0;
    word_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) tick();
    chk("drain_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iot_byte_packer.md
Name: iot_byte_packer

Overview:
Input stage directly upstream of the function processors. Collects the 8-bit iot_in byte stream into 128-bit data words, 16 bytes per word with the first byte most significant. Tags each word with its index within an 8-word round and presents it to the processors through a valid/ready handshake. Drives busy back to the byte source when both internal word buffers are full.

Parameters:
DATA_W, 128, assembled word width
BYTE_W, 8, input byte width
ROUND_WORDS, 8, words per round; word index width is log2(ROUND_WORDS)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
in_en  input  1  iot_in carries a valid byte this cycle
iot_in  input  8  data byte
flush  input  1  synchronous clear of partial word, buffers and round index (pulsed by control on function change)
busy  output  1  source must not assert in_en while high
word_valid  output  1  word_data/word_idx/round_last are valid
word_ready  input  1  consumer accepts word this cycle
word_data  output  128  assembled word
word_idx  output  3  index of word within round, 0..7
round_last  output  1  high with word_valid when word_idx == 7
overrun  output  1  sticky: a byte arrived while busy was high

Behaviour:
- Reset (rst low, asynchronous): busy=0, word_valid=0, word_data=0, word_idx=0, round_last=0, overrun=0. Byte counter=0, assembly buffer empty. Any partial word is discarded.
- Storage: an assembly shift register (asm, 128b), a 4-bit byte counter, an asm_full flag, and an output register (out, 128b) with word_valid as its full flag.
- Byte accept: in_en=1 and asm_full=0:
  - asm shifts left by 8 with iot_in entering [7:0], so byte 0 ends in [127:120].
  - Counter increments, wrapping 15->0.
- Word complete: the edge that accepts byte 15 (counter==15).
  - If out is empty, or the out handshake fires on that same edge: the completed word loads directly into out and word_valid=1 after that edge. Latency is 0 cycles from the 16th byte edge.
  - Otherwise the word stays in asm and asm_full=1.
- Handshake: word_valid & word_ready on an edge consumes out.
  - If asm_full, asm moves into out and asm_full clears; word_valid stays 1.
  - Else if a word completes on the same edge, that word loads into out.
  - Otherwise word_valid clears. word_data keeps its last value but is don't-care.
- Round index: word_idx is the index of the word in out. It is computed from a load counter that increments on every load into out and wraps 7->0. round_last = word_valid & (word_idx==7).
- busy: registered, equal to asm_full. It goes high the edge after the 16th byte when out is still occupied. It drops the edge after the handshake that drains asm.
- Overrun: in_en=1 while asm_full=1 drops the byte and sets overrun=1. overrun holds until reset; flush does not clear it.
- Flush (synchronous): clears the counter, asm_full, word_valid, busy and the load counter (next word is idx 0).
  - Flush has priority over byte accept and handshake on the same edge.
  - A byte presented with flush is discarded.
- No combinational path from in_en/iot_in to any output. word_ready affects only next-state logic.

Test Plan:
- Single word, word_ready=1: bytes 0x00..0x0F on 16 consecutive cycles -> word_valid=1 after the 16th edge, word_data=0x000102030405060708090A0B0C0D0E0F, word_idx=0, busy stays 0.
- Full round, word_ready=1: 8 words back-to-back (128 bytes) -> word_idx 0..7 in order, round_last=1 only with idx 7; the 9th word shows idx 0.
- Backpressure, word_ready=0: 32 bytes sent -> word 0 held in out and word 1 in asm, busy=1 after the 32nd byte edge. Then word_ready=1 for one cycle -> out=word 1 with idx 1, busy=0 the following cycle.
- Overrun: while busy=1, drive in_en with 0xAA -> overrun=1 and stays 1. After draining, the next 16 bytes form a word with no 0xAA in it.
- Flush mid-word: 7 bytes, then flush, then 16 bytes 0x10..0x1F -> word_data=0x101112...1F, word_idx=0.
- Async reset mid-word: drop rst between clock edges after 5 bytes -> all outputs 0 immediately. After release, 16 new bytes yield a correct word with idx 0.
